// File: rtl/board_pkg.sv
// board_pkg
//   Shared constants for the Minesweeper board plotter:
//   - tile codes (0..8 revealed neighbour count, 9 hidden, 10 flag,
//     11 mine, 12 cursor; 13..15 unused)
//   - 3-bit {R,G,B} colour constants
//   - visible screen limits used by the elaboration-time range checks
//   - FSM state encoding for the plotter
//   - count_color(): colour of the digit shown on a revealed tile
package board_pkg;

   localparam logic [3:0] CODE_MAX_COUNT = 4'd8;
   localparam logic [3:0] CODE_HIDDEN    = 4'd9;
   localparam logic [3:0] CODE_FLAG      = 4'd10;
   localparam logic [3:0] CODE_MINE      = 4'd11;
   localparam logic [3:0] CODE_CURSOR    = 4'd12;

   localparam logic [2:0] COLOR_BLACK   = 3'b000;
   localparam logic [2:0] COLOR_BLUE    = 3'b001;
   localparam logic [2:0] COLOR_GREEN   = 3'b010;
   localparam logic [2:0] COLOR_CYAN    = 3'b011;
   localparam logic [2:0] COLOR_RED     = 3'b100;
   localparam logic [2:0] COLOR_MAGENTA = 3'b101;
   localparam logic [2:0] COLOR_YELLOW  = 3'b110;
   localparam logic [2:0] COLOR_WHITE   = 3'b111;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_DRAW,
      ST_DONE
   } plot_state_t;

   // Digit colour for a revealed tile; an empty tile (0) stays white.
   function automatic logic [2:0] count_color(input logic [3:0] code);
      logic [2:0] c;
      case (code)
         4'd1:    c = COLOR_BLUE;
         4'd2:    c = COLOR_GREEN;
         4'd3:    c = COLOR_RED;
         4'd4:    c = COLOR_MAGENTA;
         4'd5:    c = COLOR_YELLOW;
         4'd6:    c = COLOR_CYAN;
         4'd7:    c = COLOR_BLACK;
         4'd8:    c = COLOR_BLACK;
         default: c = COLOR_WHITE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/board_plotter_if.sv
// board_plotter_if
//   Bundles the plotter's request, board-RAM and pixel-stream signals.
//   master : the plotter (drives board_addr and the pixel stream)
//   slave  : its environment (issues redraw, returns board_data,
//            consumes x/y/color/plot and the busy/done status)
interface board_plotter_if;
   logic       redraw;
   logic [7:0] board_addr;
   logic [3:0] board_data;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] color;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      input  redraw, board_data,
      output board_addr, x, y, color, plot, busy, done
   );

   modport slave (
      output redraw, board_data,
      input  board_addr, x, y, color, plot, busy, done
   );
endinterface

// File: rtl/board_plotter_tile_sprite_rom.sv
// tile_sprite_rom
//   Combinational glyph lookup: (tile code, pixel row, pixel col) -> colour.
//   Ports:
//     i_code  [3:0]     tile code
//     i_row   [RCW-1:0] pixel row inside the tile (0..TILE_SIZE-1)
//     i_col   [RCW-1:0] pixel column inside the tile
//     o_color [2:0]     {R,G,B}
//   Glyphs are described by position rules (centre, border, parity) so they
//   scale with TILE_SIZE; at 3x3 they give:
//     0..8   white tile, centre pixel in the count colour
//     HIDDEN solid cyan
//     FLAG   black pole in the centre column, red cloth top-left, cyan field
//     MINE   checkerboard: black on even (row+col), red on odd
//     CURSOR yellow border around a white centre
//     13..15 solid black
module tile_sprite_rom
   import board_pkg::*;
#(
   parameter int TILE_SIZE = 3,
   parameter int RCW       = 2
) (
   input  logic [3:0]     i_code,
   input  logic [RCW-1:0] i_row,
   input  logic [RCW-1:0] i_col,
   output logic [2:0]     o_color
);

   localparam logic [RCW-1:0] CENTER = RCW'(TILE_SIZE / 2);
   localparam logic [RCW-1:0] EDGE   = RCW'(TILE_SIZE - 1);

   logic w_center;
   logic w_border;
   logic w_even;

   assign w_center = (i_row == CENTER) && (i_col == CENTER);
   assign w_border = (i_row == '0) || (i_col == '0) ||
                     (i_row == EDGE) || (i_col == EDGE);
   assign w_even   = ~(i_row[0] ^ i_col[0]);

   always_comb begin
      o_color = COLOR_BLACK;
      if (i_code <= CODE_MAX_COUNT) begin
         o_color = w_center ? count_color(i_code) : COLOR_WHITE;
      end else begin
         case (i_code)
            CODE_HIDDEN: o_color = COLOR_CYAN;
            CODE_FLAG: begin
               if (i_col == CENTER)
                  o_color = COLOR_BLACK;
               else if ((i_row == '0) && (i_col < CENTER))
                  o_color = COLOR_RED;
               else
                  o_color = COLOR_CYAN;
            end
            CODE_MINE:   o_color = w_even ? COLOR_BLACK : COLOR_RED;
            CODE_CURSOR: o_color = w_border ? COLOR_YELLOW : COLOR_WHITE;
            default:     o_color = COLOR_BLACK;
         endcase
      end
   end

endmodule

// File: rtl/board_plotter.sv
// board_plotter
//   Frame-scan pixel source. A redraw request walks every board tile in
//   row-major order, fetches its code from a synchronous board RAM and
//   streams the tile's TILE_SIZE x TILE_SIZE sprite at one pixel per clock.
//   Ports:
//     CLOCK_50  system clock (rising edge)
//     resetn    asynchronous active-low reset
//     bus       board_plotter_if.master: redraw in, board_addr out,
//               board_data in (1-cycle latency), x/y/color/plot out,
//               busy/done status out
//   Per tile: FETCH (address out), LOAD (code back from RAM), then
//   TILE_SIZE^2 DRAW cycles.
module board_plotter
   import board_pkg::*;
#(
   parameter int COLS      = 16,
   parameter int ROWS      = 16,
   parameter int TILE_SIZE = 3,
   parameter int X0        = 7,
   parameter int Y0        = 7
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   board_plotter_if.master   bus
);

   localparam int CW = (COLS > 1)      ? $clog2(COLS)      : 1;
   localparam int RW = (ROWS > 1)      ? $clog2(ROWS)      : 1;
   localparam int PW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

   if (X0 + COLS * TILE_SIZE > SCREEN_W) begin : g_chk_x
      $error("board_plotter: board does not fit horizontally on screen");
   end
   if (Y0 + ROWS * TILE_SIZE > SCREEN_H) begin : g_chk_y
      $error("board_plotter: board does not fit vertically on screen");
   end
   if (COLS * ROWS > 256) begin : g_chk_tiles
      $error("board_plotter: board exceeds 256 tiles of board RAM");
   end

   plot_state_t r_state, w_state_nxt;

   logic [CW-1:0] r_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic [PW-1:0] r_px,  w_px_nxt;
   logic [PW-1:0] r_py,  w_py_nxt;
   logic [3:0]    r_code, w_code_nxt;

   logic [7:0] r_addr;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_color;
   logic       r_plot;

   logic       w_last_px, w_last_py, w_last_col, w_last_row;
   logic       w_last_pix, w_last_tile;
   logic       w_busy, w_done;
   logic [2:0] w_rom_color;

   assign w_last_px   = (r_px  == PW'(TILE_SIZE - 1));
   assign w_last_py   = (r_py  == PW'(TILE_SIZE - 1));
   assign w_last_col  = (r_col == CW'(COLS - 1));
   assign w_last_row  = (r_row == RW'(ROWS - 1));
   assign w_last_pix  = w_last_px && w_last_py;
   assign w_last_tile = w_last_col && w_last_row;

   // State register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.redraw) w_state_nxt = ST_FETCH;
         ST_FETCH: w_state_nxt = ST_LOAD;
         ST_LOAD:  w_state_nxt = ST_DRAW;
         ST_DRAW:  if (w_last_pix) w_state_nxt = w_last_tile ? ST_DONE : ST_FETCH;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs
   always_comb begin
      w_busy = (r_state != ST_IDLE);
      w_done = (r_state == ST_DONE);
   end

   // Tile/pixel counters for the pixel that will be on the outputs next
   // cycle. The output registers are loaded from these so x/y/color are
   // already valid in the first DRAW cycle.
   always_comb begin
      w_col_nxt  = r_col;
      w_row_nxt  = r_row;
      w_px_nxt   = r_px;
      w_py_nxt   = r_py;
      w_code_nxt = r_code;
      case (r_state)
         ST_IDLE: begin
            if (bus.redraw) begin
               w_col_nxt = '0;
               w_row_nxt = '0;
            end
         end
         ST_LOAD: begin
            w_code_nxt = bus.board_data;
            w_px_nxt   = '0;
            w_py_nxt   = '0;
         end
         ST_DRAW: begin
            if (!w_last_px) begin
               w_px_nxt = r_px + PW'(1);
            end else begin
               w_px_nxt = '0;
               if (!w_last_py) begin
                  w_py_nxt = r_py + PW'(1);
               end else begin
                  w_py_nxt = '0;
                  if (!w_last_col) begin
                     w_col_nxt = r_col + CW'(1);
                  end else begin
                     w_col_nxt = '0;
                     w_row_nxt = w_last_row ? '0 : r_row + RW'(1);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   tile_sprite_rom #(
      .TILE_SIZE (TILE_SIZE),
      .RCW       (PW)
   ) u_rom (
      .i_code  (w_code_nxt),
      .i_row   (w_py_nxt),
      .i_col   (w_px_nxt),
      .o_color (w_rom_color)
   );

   // Counters, RAM address and registered pixel outputs.
   // Coordinates are summed at 9 bits and then truncated to the port width.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_col   <= '0;
         r_row   <= '0;
         r_px    <= '0;
         r_py    <= '0;
         r_code  <= '0;
         r_addr  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_color <= '0;
         r_plot  <= 1'b0;
      end else begin
         r_col  <= w_col_nxt;
         r_row  <= w_row_nxt;
         r_px   <= w_px_nxt;
         r_py   <= w_py_nxt;
         r_code <= w_code_nxt;
         r_plot <= (w_state_nxt == ST_DRAW);
         if (w_state_nxt == ST_FETCH)
            r_addr <= 8'(9'(w_row_nxt) * 9'(COLS) + 9'(w_col_nxt));
         if (w_state_nxt == ST_DRAW) begin
            r_x     <= 8'(9'(X0) + 9'(w_col_nxt) * 9'(TILE_SIZE) + 9'(w_px_nxt));
            r_y     <= 7'(9'(Y0) + 9'(w_row_nxt) * 9'(TILE_SIZE) + 9'(w_py_nxt));
            r_color <= w_rom_color;
         end
      end
   end

   assign bus.board_addr = r_addr;
   assign bus.x          = r_x;
   assign bus.y          = r_y;
   assign bus.color      = r_color;
   assign bus.plot       = r_plot;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;

endmodule

// File: doc/board_plotter.md
# board_plotter

Frame-scan pixel source for the Minesweeper display. On a `redraw` pulse, walks every board tile in row-major order and fetches each tile's code from the board RAM. It then emits that tile's TILE_SIZE×TILE_SIZE sprite pixels as (x, y, color, plot) at one pixel per clock. Its outputs feed `vga_xy_controller` directly, replacing the per-tile hard-wired sprite instances at the top level.

## Interface
- `COLS`, 16, tiles per board row
- `ROWS`, 16, tile rows
- `TILE_SIZE`, 3, sprite edge in pixels; also the tile pitch
- `X0`, 7, screen x of tile (0,0) top-left pixel
- `Y0`, 7, screen y of tile (0,0) top-left pixel
- `CLOCK_50  in  1` system clock; all logic on rising edge
- `resetn  in  1` asynchronous, active-low reset
- `redraw  in  1` single-cycle request to start a full-board scan
- `board_addr  out  8` tile index row*COLS+col into board RAM
- `board_data  in  4` tile code; synchronous RAM, valid one cycle after `board_addr`
- `x  out  8` pixel x (0..159)
- `y  out  7` pixel y (0..119)
- `color  out  3` pixel color {R,G,B}
- `plot  out  1` x/y/color valid this cycle
- `busy  out  1` scan in progress
- `done  out  1` one-cycle pulse at scan completion

## Operation
- FSM states: IDLE, FETCH, LOAD, DRAW, DONE.
- IDLE: `busy`=0. `redraw`=1 → FETCH; col=row=0.
- FETCH: drive `board_addr`=row*COLS+col → LOAD.
- LOAD: latch `board_data` into the tile-code register; px=py=0 → DRAW.
- DRAW: `plot`=1.
  - x = X0 + col*TILE_SIZE + px; y = Y0 + row*TILE_SIZE + py.
  - color = sprite(code, py, px).
  - px increments each cycle. At px=TILE_SIZE-1: px←0, py++.
  - At last pixel (px=py=TILE_SIZE-1): advance col, wrapping at COLS to col=0, row++. Go to FETCH, or to DONE if this was tile (ROWS-1, COLS-1).
- DONE: `done`=1 for one cycle → IDLE.
- `board_addr` is held at its last value outside FETCH. Its value is only meaningful in FETCH.
- `redraw` outside IDLE is ignored (not queued). `redraw` in the DONE cycle is ignored.
- Unknown tile codes (13–15) render solid black (color 3'b000).
- Arithmetic:
  - Coordinates are computed at 9 bits, then truncated.
  - Elaboration check: X0+COLS*TILE_SIZE ≤ 160 and Y0+ROWS*TILE_SIZE ≤ 120.
  - COLS*ROWS ≤ 256.

## Timing
- Reset values: state IDLE; `plot`=0, `busy`=0, `done`=0, `board_addr`=0, x=0, y=0, color=0.
- Reset asserted mid-scan aborts immediately; no further pixels. After release, the block waits for a new `redraw`.
- `busy` rises the cycle after `redraw` and stays high through FETCH/LOAD/DRAW/DONE. It falls when the FSM returns to IDLE.
- First `plot` occurs 3 cycles after the `redraw` cycle.
- Per tile: 2 + TILE_SIZE² cycles (11 at defaults). Full frame at defaults: 256×11 = 2816 cycles, then 1 `done` cycle.
- `plot` is never asserted during FETCH/LOAD; gaps between tiles are exactly 2 cycles.
- x/y/color are registered outputs, stable for the whole cycle `plot`=1.

## Structure
- Package `board_pkg`: tile-code constants (0–8 = revealed count, 9 HIDDEN, 10 FLAG, 11 MINE, 12 CURSOR), the 3-bit color constants, and the screen limits 160/120.
- Sub-module `tile_sprite_rom`: combinational (code[3:0], row, col) → color[2:0]. Holds the 3×3 glyph patterns and is separately testable.
- FSM, counters and coordinate adders live in `board_plotter`.

## Test plan
- **Reset mid-scan:** reset, then `redraw` at cycle 0, then `resetn` low at cycle 100 → `plot`/`busy` go 0 asynchronously. No pixels after release until a new `redraw`.
- **First tile:** all RAM = 9 (HIDDEN), `redraw` pulse → first pixel (7,7) with HIDDEN color 3 cycles later. 9 plots cover x 7–9, y 7–9. Next plot is (10,7) after a 2-cycle gap.
- **Full frame:** `redraw` → exactly 2304 plots. `done` pulses once at cycle 2817 after `redraw`. The last pixel is (54,54). `board_addr` sequence is 0..255, each address exactly once.
- **RAM latency:** RAM model returns addr[3:0] with 1-cycle latency → each tile's rendered code matches its own address, not the previous tile's.
- **Redraw ignored while busy:** `redraw` re-pulsed at cycles 50 and 2817 (the DONE cycle) → ignored; single `done`, plot count still 2304.
- **Codes 11 and 15:** tile 0 = 11 (MINE), tile 1 = 15 → MINE glyph colors per `tile_sprite_rom`; tile 1 all nine pixels 3'b000.
